// File: rtl/controle_posicionamento_if.sv
// Button pulses in, ship position vectors and status out, between the
// button conditioning logic and the VGA ship renderers.
interface controle_posicionamento_if;
    logic        start;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_rotate;
    logic        btn_confirm;
    logic [63:0] pos_submarino;
    logic [63:0] pos_cruzador;
    logic [63:0] pos_hidroaviao;
    logic [63:0] pos_encouracado;
    logic [63:0] pos_portaavioes;
    logic [63:0] pos_cursor;
    logic [2:0]  ship_sel;
    logic        reject;
    logic        placement_done;

    // Button source / display consumer side
    modport master (
        output start, btn_up, btn_down, btn_left, btn_right, btn_rotate, btn_confirm,
        input  pos_submarino, pos_cruzador, pos_hidroaviao, pos_encouracado,
        input  pos_portaavioes, pos_cursor, ship_sel, reject, placement_done
    );

    // Placement controller side
    modport slave (
        input  start, btn_up, btn_down, btn_left, btn_right, btn_rotate, btn_confirm,
        output pos_submarino, pos_cruzador, pos_hidroaviao, pos_encouracado,
        output pos_portaavioes, pos_cursor, ship_sel, reject, placement_done
    );
endinterface

// File: rtl/controle_posicionamento.sv
// Placement controller for the 8x8 Batalha Naval board: walks the player through the
// five ships in fixed order (ship type == ship length), moves/rotates a candidate,
// refuses off-board moves and overlapping placements, and publishes the committed
// ships plus a preview cursor in the VGA cell-vector format.
module controle_posicionamento (
    input  logic clk,
    input  logic reset,
    controle_posicionamento_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StMove, StCheck, StCommit, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  ship_q, ship_d;        // 1..5, also the ship length
    logic [3:0]  ax_q, ax_d;            // anchor X, 1..8
    logic [3:0]  ay_q, ay_d;            // anchor Y, 1..8
    logic        vert_q, vert_d;        // 0 = horizontal, 1 = vertical
    logic [63:0] occ_q, occ_d;          // bit (y-1)*8+(x-1) set when a cell is taken
    logic [63:0] pos_q [5];
    logic [63:0] pos_d [5];
    logic [63:0] cursor_q, cursor_d;
    logic [2:0]  ship_sel_q, ship_sel_d;
    logic        reject_q, reject_d;
    logic        done_q, done_d;

    logic [63:0] cand_vec_q;
    logic [63:0] cand_mask_q;

    // True when every cell of a ship of length len anchored at (ax,ay) lies in 1..8.
    function automatic logic ship_fits(input logic [2:0] len, input logic [3:0] ax,
                                       input logic [3:0] ay, input logic vert);
        logic [4:0] far;
        far = vert ? ({1'b0, ay} + {2'b0, len} - 5'd1) : ({1'b0, ax} + {2'b0, len} - 5'd1);
        return (ax >= 4'd1) && (ay >= 4'd1) && (ax <= 4'd8) && (ay <= 4'd8) && (far <= 5'd8);
    endfunction

    // Cell-vector encoding: type in [2:0], cell k X in [6+8k -:4], Y in [10+8k -:4].
    function automatic logic [63:0] cand_vec(input logic [2:0] len, input logic [3:0] ax,
                                             input logic [3:0] ay, input logic vert);
        logic [63:0] v;
        logic [3:0]  cx;
        logic [3:0]  cy;
        v = '0;
        v[2:0] = len;
        for (int k = 0; k < 7; k++) begin
            cx = vert ? ax : ax + 4'(k);
            cy = vert ? ay + 4'(k) : ay;
            if (3'(k) < len) begin
                v[6 + 8*k -: 4]  = cx;
                v[10 + 8*k -: 4] = cy;
            end
        end
        return v;
    endfunction

    // Occupancy-map footprint of the candidate; only meaningful for on-board ships.
    function automatic logic [63:0] cand_mask(input logic [2:0] len, input logic [3:0] ax,
                                              input logic [3:0] ay, input logic vert);
        logic [63:0] m;
        logic [3:0]  cx;
        logic [3:0]  cy;
        logic [5:0]  idx;
        m = '0;
        for (int k = 0; k < 5; k++) begin
            cx  = vert ? ax : ax + 4'(k);
            cy  = vert ? ay + 4'(k) : ay;
            idx = {3'(cy - 4'd1), 3'(cx - 4'd1)};
            if (3'(k) < len) begin
                m[idx] = 1'b1;
            end
        end
        return m;
    endfunction

    // Current candidate, shared by the overlap check and the commit write.
    always_comb begin
        cand_vec_q  = cand_vec(ship_q, ax_q, ay_q, vert_q);
        cand_mask_q = cand_mask(ship_q, ax_q, ay_q, vert_q);
    end

    // State register plus placement datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ship_q     <= 3'd0;
            ax_q       <= 4'd1;
            ay_q       <= 4'd1;
            vert_q     <= 1'b0;
            occ_q      <= '0;
            for (int i = 0; i < 5; i++) begin
                pos_q[i] <= '0;
            end
            cursor_q   <= '0;
            ship_sel_q <= 3'd0;
            reject_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ship_q     <= ship_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            vert_q     <= vert_d;
            occ_q      <= occ_d;
            for (int i = 0; i < 5; i++) begin
                pos_q[i] <= pos_d[i];
            end
            cursor_q   <= cursor_d;
            ship_sel_q <= ship_sel_d;
            reject_q   <= reject_d;
            done_q     <= done_d;
        end
    end

    // Next-state and datapath: one button action per cycle, confirm highest priority.
    always_comb begin
        state_d  = state_q;
        ship_d   = ship_q;
        ax_d     = ax_q;
        ay_d     = ay_q;
        vert_d   = vert_q;
        occ_d    = occ_q;
        reject_d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pos_d[i] = pos_q[i];
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StMove;
                    ship_d  = 3'd1;
                    ax_d    = 4'd1;
                    ay_d    = 4'd1;
                    vert_d  = 1'b0;
                end
            end
            StMove: begin
                if (bus.btn_confirm) begin
                    state_d = StCheck;
                end else if (bus.btn_rotate) begin
                    if (ship_fits(ship_q, ax_q, ay_q, ~vert_q)) vert_d = ~vert_q;
                end else if (bus.btn_up) begin
                    if (ship_fits(ship_q, ax_q, ay_q + 4'd1, vert_q)) ay_d = ay_q + 4'd1;
                end else if (bus.btn_down) begin
                    if (ship_fits(ship_q, ax_q, ay_q - 4'd1, vert_q)) ay_d = ay_q - 4'd1;
                end else if (bus.btn_left) begin
                    if (ship_fits(ship_q, ax_q - 4'd1, ay_q, vert_q)) ax_d = ax_q - 4'd1;
                end else if (bus.btn_right) begin
                    if (ship_fits(ship_q, ax_q + 4'd1, ay_q, vert_q)) ax_d = ax_q + 4'd1;
                end
            end
            StCheck: begin
                if (|(cand_mask_q & occ_q)) begin
                    reject_d = 1'b1;
                    state_d  = StMove;
                end else begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                for (int i = 0; i < 5; i++) begin
                    if (ship_q == 3'(i + 1)) pos_d[i] = cand_vec_q;
                end
                occ_d = occ_q | cand_mask_q;
                if (ship_q == 3'd5) begin
                    state_d = StDone;
                end else begin
                    state_d = StMove;
                    ship_d  = ship_q + 3'd1;
                    ax_d    = 4'd1;
                    ay_d    = 4'd1;
                    vert_d  = 1'b0;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs track it without lag.
    always_comb begin
        cursor_d   = '0;
        ship_sel_d = 3'd0;
        done_d     = 1'b0;
        unique case (state_d)
            StMove, StCheck, StCommit: begin
                cursor_d   = cand_vec(ship_d, ax_d, ay_d, vert_d);
                ship_sel_d = ship_d;
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.pos_submarino   = pos_q[0];
    assign bus.pos_cruzador    = pos_q[1];
    assign bus.pos_hidroaviao  = pos_q[2];
    assign bus.pos_encouracado = pos_q[3];
    assign bus.pos_portaavioes = pos_q[4];
    assign bus.pos_cursor      = cursor_q;
    assign bus.ship_sel        = ship_sel_q;
    assign bus.reject          = reject_q;
    assign bus.placement_done  = done_q;

endmodule

// File: tb/tb_controle_posicionamento.sv
// Directed bench for the placement controller with an expectation scoreboard.
module tb_controle_posicionamento;

    localparam logic [6:0] BUp    = 7'h01;
    localparam logic [6:0] BDown  = 7'h02;
    localparam logic [6:0] BLeft  = 7'h04;
    localparam logic [6:0] BRight = 7'h08;
    localparam logic [6:0] BRot   = 7'h10;
    localparam logic [6:0] BConf  = 7'h20;
    localparam logic [6:0] BStart = 7'h40;

    // Field ids: 0..4 pos_* in ship order, 5 cursor, 6 ship_sel, 7 reject, 8 done
    localparam int FCur  = 5;
    localparam int FSel  = 6;
    localparam int FRej  = 7;
    localparam int FDone = 8;

    typedef struct {
        string       tag;
        int          field;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    controle_posicionamento_if bus ();

    controle_posicionamento dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference encoding built from shifts of the cell coordinates.
    function automatic logic [63:0] mkvec(input int t, input int x, input int y, input int vert);
        logic [63:0] v;
        v = 64'(t);
        for (int i = 0; i < t; i++) begin
            int cx;
            int cy;
            cx = (vert != 0) ? x : x + i;
            cy = (vert != 0) ? y + i : y;
            v = v | (64'(cx) << (3 + 8*i)) | (64'(cy) << (7 + 8*i));
        end
        return v;
    endfunction

    function automatic logic [63:0] observe(input int field);
        case (field)
            0:       return bus.pos_submarino;
            1:       return bus.pos_cruzador;
            2:       return bus.pos_hidroaviao;
            3:       return bus.pos_encouracado;
            4:       return bus.pos_portaavioes;
            FCur:    return bus.pos_cursor;
            FSel:    return 64'(bus.ship_sel);
            FRej:    return 64'(bus.reject);
            default: return 64'(bus.placement_done);
        endcase
    endfunction

    function automatic void push(input string tag, input int field, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.field = field;
        e.val = val;
        sb.push_back(e);
    endfunction

    // Compare every pending expectation against the current outputs.
    task automatic check_sb();
        exp_t e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.field);
            n_checks++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] b);
        bus.btn_up      = b[0];
        bus.btn_down    = b[1];
        bus.btn_left    = b[2];
        bus.btn_right   = b[3];
        bus.btn_rotate  = b[4];
        bus.btn_confirm = b[5];
        bus.start       = b[6];
        tick();
        bus.btn_up      = 1'b0;
        bus.btn_down    = 1'b0;
        bus.btn_left    = 1'b0;
        bus.btn_right   = 1'b0;
        bus.btn_rotate  = 1'b0;
        bus.btn_confirm = 1'b0;
        bus.start       = 1'b0;
    endtask

    task automatic expect_cleared(input string tag);
        for (int f = 0; f <= FDone; f++) begin
            push(tag, f, 64'd0);
        end
        check_sb();
    endtask

    // Ship s placed horizontally at (1, 1+ups) with no overlap expected.
    task automatic place(input int s, input int ups);
        repeat (ups) drive(BUp);
        drive(BConf);
        tick();
        tick();
        push("place_pos", s - 1, mkvec(s, 1, 1 + ups, 0));
        push("place_sel", FSel, (s == 5) ? 64'd0 : 64'(s + 1));
        check_sb();
    endtask

    initial begin
        drive(7'h00);
        tick();
        reset = 1'b0;
        expect_cleared("reset");

        drive(BUp | BRight | BConf);
        push("idle_cur", FCur, 64'd0);
        push("idle_sel", FSel, 64'd0);
        check_sb();

        drive(BStart);
        push("start_sel", FSel, 64'd1);
        push("start_cur", FCur, 64'h89);
        check_sb();

        drive(BConf);
        push("chk_cur", FCur, 64'h89);
        push("chk_rej", FRej, 64'd0);
        check_sb();
        tick();
        push("commit_rej", FRej, 64'd0);
        check_sb();
        tick();
        push("sub_pos", 0, 64'h0000_0000_0000_0089);
        push("sub_sel", FSel, 64'd2);
        push("cruz_cur", FCur, 64'h908A);
        check_sb();

        // Cruzador: walk to the right edge, then try to step past it
        repeat (4) drive(BRight);
        drive(BRight);
        push("right_ax6", FCur, mkvec(2, 6, 1, 0));
        check_sb();
        drive(BRight);
        push("right_ax7", FCur, mkvec(2, 7, 1, 0));
        check_sb();
        drive(BRight);
        push("right_edge", FCur, mkvec(2, 7, 1, 0));
        push("right_edge_rej", FRej, 64'd0);
        check_sb();
        repeat (7) drive(BUp);
        push("top_row", FCur, mkvec(2, 7, 8, 0));
        check_sb();
        drive(BRot);
        push("rot_refused", FCur, mkvec(2, 7, 8, 0));
        check_sb();

        // Back onto the submarine to force an overlap
        repeat (6) drive(BLeft);
        repeat (7) drive(BDown);
        push("home", FCur, mkvec(2, 1, 1, 0));
        check_sb();
        drive(BConf);
        tick();
        push("ovl_rej", FRej, 64'd1);
        push("ovl_sel", FSel, 64'd2);
        push("ovl_cur", FCur, mkvec(2, 1, 1, 0));
        check_sb();
        tick();
        push("ovl_rej_end", FRej, 64'd0);
        push("ovl_pos", 1, 64'd0);
        push("ovl_sel2", FSel, 64'd2);
        check_sb();

        drive(BRot);
        push("rot_ok", FCur, mkvec(2, 1, 1, 1));
        check_sb();
        drive(BRight);
        push("vert_right", FCur, mkvec(2, 2, 1, 1));
        check_sb();
        drive(BConf | BRight);
        push("conf_prio", FCur, mkvec(2, 2, 1, 1));
        check_sb();
        tick();
        tick();
        push("cruz_pos", 1, mkvec(2, 2, 1, 1));
        push("cruz_sel", FSel, 64'd3);
        push("hidro_cur", FCur, mkvec(3, 1, 1, 0));
        check_sb();

        place(3, 2);

        // Encouracado goes to CHECK, then reset lands in that cycle
        repeat (3) drive(BUp);
        drive(BConf);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_cleared("reset_chk");
        drive(BUp);
        push("post_reset_cur", FCur, 64'd0);
        check_sb();

        // Full sequence after reset; first placement also shows occupancy was cleared
        drive(BStart);
        place(1, 0);
        place(2, 1);
        place(3, 2);
        place(4, 3);
        place(5, 4);
        push("done", FDone, 64'd1);
        push("done_cur", FCur, 64'd0);
        push("done_sel", FSel, 64'd0);
        check_sb();

        drive(BStart | BConf | BUp);
        drive(BRot);
        push("done_hold", FDone, 64'd1);
        push("done_hold_cur", FCur, 64'd0);
        push("done_hold_pa", 4, mkvec(5, 1, 5, 0));
        push("done_hold_sub", 0, mkvec(1, 1, 1, 0));
        check_sb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
